// File: rtl/heap_pkg.sv
// heap_pkg: shared definitions for the heap request sequencer.
//   - heap Memory action codes (1..30) and the largest legal code
//   - local error code returned for an unknown action
//   - sequencer FSM state type
//   - action_valid(): legality test for an action code
package heap_pkg;

  localparam logic [7:0] ACT_RESET   = 8'd1;
  localparam logic [7:0] ACT_ALLOC   = 8'd2;
  localparam logic [7:0] ACT_FREE    = 8'd3;
  localparam logic [7:0] ACT_SIZE    = 8'd4;
  localparam logic [7:0] ACT_READ    = 8'd5;
  localparam logic [7:0] ACT_WRITE   = 8'd6;
  localparam logic [7:0] ACT_EQUAL   = 8'd7;
  localparam logic [7:0] ACT_LESS    = 8'd8;
  localparam logic [7:0] ACT_GREATER = 8'd9;
  localparam logic [7:0] ACT_UP      = 8'd10;
  localparam logic [7:0] ACT_DOWN    = 8'd11;
  localparam logic [7:0] ACT_LEFT    = 8'd12;
  localparam logic [7:0] ACT_RIGHT   = 8'd13;
  localparam logic [7:0] ACT_PUSH    = 8'd14;
  localparam logic [7:0] ACT_POP     = 8'd15;
  localparam logic [7:0] ACT_PEEK    = 8'd16;
  localparam logic [7:0] ACT_SWAP    = 8'd17;
  localparam logic [7:0] ACT_COPY    = 8'd18;
  localparam logic [7:0] ACT_MOVE    = 8'd19;
  localparam logic [7:0] ACT_FILL    = 8'd20;
  localparam logic [7:0] ACT_CLEAR   = 8'd21;
  localparam logic [7:0] ACT_ADD     = 8'd22;
  localparam logic [7:0] ACT_SUB     = 8'd23;
  localparam logic [7:0] ACT_MUL     = 8'd24;
  localparam logic [7:0] ACT_DIV     = 8'd25;
  localparam logic [7:0] ACT_MOD     = 8'd26;
  localparam logic [7:0] ACT_NEG     = 8'd27;
  localparam logic [7:0] ACT_NOT     = 8'd28;
  localparam logic [7:0] ACT_OR      = 8'd29;
  localparam logic [7:0] ACT_AND     = 8'd30;

  localparam logic [7:0]  ACTION_MAX     = 8'd30;
  localparam logic [31:0] ERR_BAD_ACTION = 32'd10000280;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    SAMPLE = 3'd3,
    RESP   = 3'd4
  } seq_state_t;

  function automatic logic action_valid(input logic [7:0] a);
    return (a != 8'd0) && (a <= ACTION_MAX);
  endfunction

endpackage

// File: rtl/heap_request_sequencer_if.sv
// heap_request_sequencer_if: request and response valid/ready channels of
// the heap request sequencer.
//   req_*  : request channel (valid/ready, action, array, index, in)
//   resp_* : response channel (valid/ready, action, out, error)
// Modports: master = request producer / response consumer,
//           slave  = the sequencer.
interface heap_request_sequencer_if #(
  parameter int ADDRESS_BITS = 8,
  parameter int INDEX_BITS   = 3,
  parameter int DATA_BITS    = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic [7:0]              req_action;
  logic [ADDRESS_BITS-1:0] req_array;
  logic [INDEX_BITS-1:0]   req_index;
  logic [DATA_BITS-1:0]    req_in;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [7:0]              resp_action;
  logic [DATA_BITS-1:0]    resp_out;
  logic [31:0]             resp_error;

  modport master (
    output req_valid, req_action, req_array, req_index, req_in, resp_ready,
    input  req_ready, resp_valid, resp_action, resp_out, resp_error
  );

  modport slave (
    input  req_valid, req_action, req_array, req_index, req_in, resp_ready,
    output req_ready, resp_valid, resp_action, resp_out, resp_error
  );
endinterface

// File: rtl/heap_req_fifo.sv
// heap_req_fifo: synchronous FIFO, asynchronous active-high reset.
//   clock, reset : clock and reset
//   push, din    : write request and data (ignored when full)
//   pop, dout    : read request (ignored when empty); dout shows the head
//   full, empty  : status
// Pointers carry one extra wrap bit; full when only that bit differs.
module heap_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] store [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) store[wptr[AW-1:0]] <= din;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = store[rptr[AW-1:0]];
endmodule

// File: rtl/heap_request_sequencer.sv
// heap_request_sequencer: upstream driver of the heap Memory block.
// Buffers requests in a FIFO and issues each one to the memory with exactly
// one mem_clock transition, then returns one response per request, in order.
//   clock, reset        : clock, asynchronous active-high reset
//   bus (slave)         : request/response valid/ready channels
//   mem_clock           : transition strobe (only edges matter, not level)
//   mem_action/array/index/in : operation presented to the memory
//   mem_out, mem_error  : memory results, captured after the strobe
//   busy                : FIFO non-empty or FSM not IDLE
// Optional build macro HEAP_SEQ_STATS_EN adds stat_ops / stat_errors
// (saturating 32-bit counters).
//
// state  | meaning
// IDLE   | mem_action at no-op; pop head if present
// SETUP  | memory inputs settle; mem_clock flips on exit
// STROBE | memory acts on the transition; out/error captured on exit
// SAMPLE | captured response settles, mem_action back at no-op
// RESP   | resp_valid held until resp_ready
module heap_request_sequencer
  import heap_pkg::*;
#(
  parameter int ADDRESS_BITS = 8,
  parameter int INDEX_BITS   = 3,
  parameter int DATA_BITS    = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  heap_request_sequencer_if.slave bus,
  output logic                    mem_clock,
  output logic [7:0]              mem_action,
  output logic [ADDRESS_BITS-1:0] mem_array,
  output logic [INDEX_BITS-1:0]   mem_index,
  output logic [DATA_BITS-1:0]    mem_in,
  input  logic [DATA_BITS-1:0]    mem_out,
  input  logic [31:0]             mem_error,
  output logic                    busy
`ifdef HEAP_SEQ_STATS_EN
  ,
  output logic [31:0]             stat_ops,
  output logic [31:0]             stat_errors
`endif
);
  localparam int ENTRY_W = 8 + ADDRESS_BITS + INDEX_BITS + DATA_BITS;
  localparam int IDX_LSB = DATA_BITS;
  localparam int ARR_LSB = DATA_BITS + INDEX_BITS;
  localparam int ACT_LSB = DATA_BITS + INDEX_BITS + ADDRESS_BITS;

  seq_state_t state, next_state;

  logic [ENTRY_W-1:0]      fifo_din, fifo_dout;
  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]              head_action;
  logic [ADDRESS_BITS-1:0] head_array;
  logic [INDEX_BITS-1:0]   head_index;
  logic [DATA_BITS-1:0]    head_in;
  logic                    good_pop, bad_pop;

  logic [7:0]              resp_action_r;
  logic [DATA_BITS-1:0]    resp_out_r;
  logic [31:0]             resp_error_r;

  assign fifo_din  = {bus.req_action, bus.req_array, bus.req_index, bus.req_in};
  assign fifo_push = bus.req_valid && !fifo_full;
  assign bus.req_ready = !fifo_full;

  heap_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_action = fifo_dout[ACT_LSB +: 8];
  assign head_array  = fifo_dout[ARR_LSB +: ADDRESS_BITS];
  assign head_index  = fifo_dout[IDX_LSB +: INDEX_BITS];
  assign head_in     = fifo_dout[0 +: DATA_BITS];

  assign good_pop = (state == IDLE) && !fifo_empty && action_valid(head_action);
  assign bad_pop  = (state == IDLE) && !fifo_empty && !action_valid(head_action);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = action_valid(head_action) ? SETUP : RESP;
        end
      end
      SETUP:  next_state = STROBE;
      STROBE: next_state = SAMPLE;
      SAMPLE: next_state = RESP;
      RESP:   if (bus.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_clock     <= 1'b0;
      mem_action    <= '0;
      mem_array     <= '0;
      mem_index     <= '0;
      mem_in        <= '0;
      resp_action_r <= '0;
      resp_out_r    <= '0;
      resp_error_r  <= '0;
    end else begin
      if (good_pop) begin
        mem_action <= head_action;
        mem_array  <= head_array;
        mem_index  <= head_index;
        mem_in     <= head_in;
      end
      if (bad_pop) begin
        resp_action_r <= head_action;
        resp_out_r    <= '0;
        resp_error_r  <= ERR_BAD_ACTION;
      end
      if (state == SETUP) mem_clock <= ~mem_clock;
      if (state == STROBE) begin
        resp_action_r <= mem_action;
        resp_out_r    <= mem_out;
        resp_error_r  <= mem_error;
        mem_action    <= '0;
      end
    end
  end

  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_action = resp_action_r;
  assign bus.resp_out    = resp_out_r;
  assign bus.resp_error  = resp_error_r;
  assign busy            = !fifo_empty || (state != IDLE);

`ifdef HEAP_SEQ_STATS_EN
  logic count_op, count_err;

  // Count on the edge that loads the response registers, using the value
  // being loaded; a bad action always loads a non-zero error.
  assign count_op  = (state == STROBE) || bad_pop;
  assign count_err = ((state == STROBE) && (mem_error != 32'd0)) || bad_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_ops    <= '0;
      stat_errors <= '0;
    end else begin
      if (count_op && (stat_ops != '1))     stat_ops    <= stat_ops + 1'b1;
      if (count_err && (stat_errors != '1)) stat_errors <= stat_errors + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_heap_request_sequencer.sv
// tb_heap_request_sequencer: directed bench for heap_request_sequencer.
// The memory stub answers every mem_clock transition with out = in + 3 and
// a settable error, and counts transitions outside reset.
// Build with HEAP_SEQ_STATS_EN to also check the statistics counters.
module tb_heap_request_sequencer;
  import heap_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_clock;
  logic [7:0]  mem_action;
  logic [7:0]  mem_array;
  logic [2:0]  mem_index;
  logic [15:0] mem_in;
  logic [15:0] mem_out = '0;
  logic [31:0] mem_error = '0;
  logic        busy;
  logic [31:0] stub_err = '0;
  int          toggles = 0;
  int          n_checks = 0;
  int          n_fail = 0;
`ifdef HEAP_SEQ_STATS_EN
  logic [31:0] stat_ops, stat_errors;
`endif

  heap_request_sequencer_if #(.ADDRESS_BITS(8), .INDEX_BITS(3), .DATA_BITS(16)) bus ();

  heap_request_sequencer #(
    .ADDRESS_BITS (8),
    .INDEX_BITS   (3),
    .DATA_BITS    (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .mem_clock  (mem_clock),
    .mem_action (mem_action),
    .mem_array  (mem_array),
    .mem_index  (mem_index),
    .mem_in     (mem_in),
    .mem_out    (mem_out),
    .mem_error  (mem_error),
    .busy       (busy)
`ifdef HEAP_SEQ_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_errors (stat_errors)
`endif
  );

  always #5 clock = ~clock;

  always @(mem_clock) begin
    if (!reset) begin
      toggles   = toggles + 1;
      mem_out   = mem_in + 16'd3;
      mem_error = stub_err;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_req(input string tag, input logic [7:0] a, input logic [7:0] arr,
                          input logic [2:0] idx, input logic [15:0] din);
    int n = 0;
    @(negedge clock);
    while (!bus.req_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!bus.req_ready) begin
      chk({tag, "_ready_timeout"}, bus.req_ready, 1);
      return;
    end
    bus.req_action = a;
    bus.req_array  = arr;
    bus.req_index  = idx;
    bus.req_in     = din;
    bus.req_valid  = 1'b1;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic get_resp(input string tag, input logic [7:0] ea, input logic [15:0] eo,
                          input logic [31:0] ee);
    int n = 0;
    @(negedge clock);
    while (!bus.resp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!bus.resp_valid) begin
      chk({tag, "_timeout"}, bus.resp_valid, 1);
      return;
    end
    chk({tag, "_action"}, bus.resp_action, ea);
    chk({tag, "_out"}, bus.resp_out, eo);
    chk({tag, "_error"}, bus.resp_error, ee);
    bus.resp_ready = 1'b1;
    @(posedge clock);
    #1 bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [7:0]  bp_act [5] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd10};
  logic [15:0] bp_in  [5] = '{16'h0010, 16'h0020, 16'h1000, 16'hFFFF, 16'h00FD};
  logic [15:0] bp_out [5] = '{16'h0013, 16'h0023, 16'h1003, 16'h0002, 16'h0100};

  initial begin
    int t0;
    int seen;
    bus.req_valid  = 1'b0;
    bus.req_action = '0;
    bus.req_array  = '0;
    bus.req_index  = '0;
    bus.req_in     = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // reset state
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_clock", mem_clock, 0);
    chk("rst_mem_action", mem_action, 0);
    chk("rst_resp_error", bus.resp_error, 0);

    // single request with latency check: Size(4), array 2
    t0 = toggles;
    @(negedge clock);
    bus.req_action = ACT_SIZE;
    bus.req_array  = 8'd2;
    bus.req_index  = 3'd1;
    bus.req_in     = 16'h0000;
    bus.req_valid  = 1'b1;
    @(posedge clock);              // N
    #1 bus.req_valid = 1'b0;
    @(posedge clock); #1;          // N+1
    chk("lat_n1_mem_action", mem_action, 4);
    chk("lat_n1_mem_array", mem_array, 2);
    chk("lat_n1_toggles", toggles - t0, 0);
    @(posedge clock); #1;          // N+2
    chk("lat_n2_toggles", toggles - t0, 1);
    @(posedge clock); #1;          // N+3
    chk("lat_n3_resp_valid", bus.resp_valid, 0);
    @(posedge clock); #1;          // N+4
    chk("lat_n4_resp_valid", bus.resp_valid, 1);
    chk("single_out", bus.resp_out, 3);
    chk("single_error", bus.resp_error, 0);
    chk("single_action", bus.resp_action, 4);
    chk("single_mem_action_idle", mem_action, 0);
    bus.resp_ready = 1'b1;
    @(posedge clock);
    #1 bus.resp_ready = 1'b0;
    chk("single_done_valid", bus.resp_valid, 0);
    chk("single_done_busy", busy, 0);
    chk("single_toggles", toggles - t0, 1);

    // five back-to-back requests under backpressure
    t0 = toggles;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i > 0) chk($sformatf("bp_ready_after_%0d", i), bus.req_ready, 1);
      bus.req_action = bp_act[i];
      bus.req_array  = 8'(i + 3);
      bus.req_index  = 3'(i);
      bus.req_in     = bp_in[i];
      bus.req_valid  = 1'b1;
      @(posedge clock);
    end
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    chk("bp_ready_full", bus.req_ready, 0);
    chk("bp_busy", busy, 1);
    for (int i = 0; i < 5; i++)
      get_resp($sformatf("bp_resp%0d", i), bp_act[i], bp_out[i], 32'd0);
    chk("bp_toggles", toggles - t0, 5);
    chk("bp_busy_end", busy, 0);
    chk("bp_ready_end", bus.req_ready, 1);

    // illegal actions, then a normal Greater(9)
    t0 = toggles;
    push_req("bad0", 8'd0, 8'd1, 3'd0, 16'h1234);
    push_req("bad31", 8'd31, 8'd1, 3'd0, 16'h1234);
    push_req("gt", ACT_GREATER, 8'd7, 3'd5, 16'h0100);
    get_resp("bad0", 8'd0, 16'h0000, 32'd10000280);
    get_resp("bad31", 8'd31, 16'h0000, 32'd10000280);
    chk("bad_toggles", toggles - t0, 0);
    get_resp("gt", 8'd9, 16'h0103, 32'd0);
    chk("gt_toggles", toggles - t0, 1);

    // reset while in STROBE
    @(negedge clock);
    bus.req_action = ACT_UP;
    bus.req_array  = 8'd4;
    bus.req_index  = 3'd2;
    bus.req_in     = 16'h0040;
    bus.req_valid  = 1'b1;
    @(posedge clock);              // N
    #1 bus.req_valid = 1'b0;
    @(posedge clock);              // N+1
    @(posedge clock);              // N+2, now in STROBE
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_clock", mem_clock, 0);
    chk("midrst_mem_action", mem_action, 0);
    chk("midrst_mem_array", mem_array, 0);
    chk("midrst_resp_valid", bus.resp_valid, 0);
    chk("midrst_resp_out", bus.resp_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", bus.req_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.resp_valid) seen++;
    end
    bus.resp_ready = 1'b0;
    chk("midrst_no_resp", seen, 0);
    t0 = toggles;
    push_req("after_rst", ACT_LEFT, 8'd9, 3'd3, 16'h0007);
    get_resp("after_rst", 8'd12, 16'h000A, 32'd0);
    chk("after_rst_toggles", toggles - t0, 1);

    // error passthrough from memory
    do_reset();
    stub_err = 32'd100000274;
    push_req("down", ACT_DOWN, 8'd5, 3'd4, 16'h0200);
    get_resp("down", 8'd11, 16'h0203, 32'd100000274);
    stub_err = 32'd0;
`ifdef HEAP_SEQ_STATS_EN
    chk("stat_ops", stat_ops, 1);
    chk("stat_errors", stat_errors, 1);
`endif
    chk("end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/heap_request_sequencer.md
Name: heap_request_sequencer

Overview:
- Upstream driver of the heap Memory block.
- Accepts heap operation requests over a valid/ready interface and buffers them in a small FIFO.
- Issues each request to the memory port by producing exactly one mem_clock transition per request, since the memory acts on every transition of its clock input.
- Captures out/error and returns one response per request over a valid/ready interface. Replaces ad-hoc heapClock toggling in test programs.

Parameters:
- ADDRESS_BITS, 8, bits in a memory array number
- INDEX_BITS, 3, bits in an index within an array
- DATA_BITS, 16, width of an element
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2, ≥2

Ports:
- clock  in  1  driving clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept a request
- req_action  in  8  operation code (1..30)
- req_array  in  ADDRESS_BITS  target array
- req_index  in  INDEX_BITS  index within array
- req_in  in  DATA_BITS  input data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_action  out  8  action code the response belongs to
- resp_out  out  DATA_BITS  memory out captured for this request
- resp_error  out  32  memory error, or local error code
- mem_clock  out  1  transition strobe to memory clock
- mem_action  out  8  to memory action
- mem_array  out  ADDRESS_BITS  to memory array
- mem_index  out  INDEX_BITS  to memory index
- mem_in  out  DATA_BITS  to memory in
- mem_out  in  DATA_BITS  from memory out
- mem_error  in  32  from memory error
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, active-high): FIFO empty; FSM=IDLE; every output 0 except req_ready=1. mem_action=0 is a no-op code, so a mem_clock 1->0 edge caused by reset is harmless.
- Accept: push when req_valid && req_ready at posedge. req_ready = !full; a pop in the same cycle does not free space for a push.
- FSM states: IDLE, SETUP, STROBE, SAMPLE, RESP.
  - IDLE: mem_action held 0. If FIFO non-empty, pop the head.
    - Valid action (1..30): load mem_action/array/index/in; go to SETUP.
    - Action 0 or >30: set resp_out=0, resp_error=10000280, resp_action=code; go to RESP with no strobe.
  - SETUP: inputs stable for one full cycle; go to STROBE.
  - STROBE: invert mem_clock (exactly one transition per operation); go to SAMPLE.
  - SAMPLE: register resp_out=mem_out, resp_error=mem_error, resp_action=mem_action; set mem_action=0; go to RESP.
  - RESP: resp_valid=1 and response fields held stable until resp_ready at a posedge; then go to IDLE.
- Latency: a request accepted at edge N into an empty FIFO with FSM IDLE is popped at N+1, strobed at N+2, captured at N+3. resp_valid is high from N+4 at the earliest.
- Throughput: one operation per 5 cycles with resp_ready held high.
- Ordering: responses are returned strictly in request order. Each accepted request yields exactly one response.
- Backpressure: with resp_ready low, the FIFO continues to fill up to FIFO_DEPTH. One extra request may sit in the FSM.
- Wrap-around: FIFO read/write pointers carry one extra bit; full/empty are decided by comparing the MSB.
- Reset mid-operation: any in-flight operation is abandoned and no response is produced. An operation already strobed is not undone in memory.
- mem_clock level is not reset between operations. Only its transitions are meaningful.

Optional Feature:
- Macro: HEAP_SEQ_STATS_EN.
- Defined: adds outputs stat_ops (32) and stat_errors (32), both reset to 0.
  - stat_ops increments on each SAMPLE or invalid-action pop.
  - stat_errors increments when the registered resp_error != 0.
  - Both saturate at 2^32-1.
- Undefined: the ports are absent and no counter logic is generated.

Decomposition:
- Shared package heap_pkg:
  - action code constants 1..30 (Reset..And);
  - ACTION_MAX=30;
  - ERR_BAD_ACTION=10000280;
  - seq_state_t enum {IDLE,SETUP,STROBE,SAMPLE,RESP}.
- Sub-module heap_req_fifo: synchronous FIFO with async reset, parameters WIDTH and DEPTH, ports push/pop/full/empty/din/dout. Its entry width is 8+ADDRESS_BITS+INDEX_BITS+DATA_BITS.

Test Plan:
- Single request: Size(4), array 2, with the memory stub returning out=3, error=0. Expect exactly one mem_clock transition; resp_valid at edge N+4 with resp_out=3, resp_error=0, resp_action=4.
- Five back-to-back requests, resp_ready=0: req_ready drops after the 5th accept (4 in FIFO, 1 in FSM). Then raise resp_ready: expect 5 responses in order, 5 mem_clock transitions, and busy=0 at the end.
- Bad action: action 0, then 31. Expect two responses with resp_error=10000280 and no mem_clock transition; a following Greater(9) request proceeds normally.
- Reset asserted during STROBE: all outputs return to reset values immediately. After release, no response appears; a new request completes normally.
- Error passthrough: Down(11) with the memory stub returning error=100000274. Expect resp_error=100000274. With HEAP_SEQ_STATS_EN defined, expect stat_ops=1 and stat_errors=1.
